// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR.
// Holds the saturating/rounding helper that fir_filter_tdm uses when FIR_SAT_EN is defined.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Wide enough to hold any accumulator this block can be configured with.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_round(input logic signed [SAT_W-1:0] v,
                                                        input int shift, input int out_w);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    r   = (shift > 0) ? ((v + (one <<< (shift - 1))) >>> shift) : v;
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Serial multiply-accumulate: registered full-precision product followed by a wide accumulator.
module fir_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     mul_en,
  input  logic                     acc_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  always_comb begin
    prod_d = prod_q;
    acc_d  = acc_q;
    if (clr) begin
      prod_d = '0;
      acc_d  = '0;
    end else begin
      if (mul_en) prod_d = a * b;
      if (acc_en) acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fir_filter_tdm.sv
// Multi-channel FIR sharing one serial MAC; per-channel delay lines, runtime-loadable coefficients.
// Optional FIR_SAT_EN: round-half-up Q1.(COEF_W-1) scaling with saturation instead of wrapping.
module fir_filter_tdm
  import fir_pkg::*;
#(
  parameter int  DATA_W   = 16,
  parameter int  COEF_W   = 16,
  parameter int  TAPS     = 8,
  parameter int  CHANNELS = 4,
  parameter int  OUT_W    = 32,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TAP_W    = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  y_out,
  input  logic                     coef_we,
  input  logic [TAP_W-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     started_q;
  logic                     coef_err_q, coef_err_d;
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [COEF_W-1:0] coef_d [TAPS];
  logic signed [DATA_W-1:0] dly_q  [CHANNELS][TAPS];
  logic signed [DATA_W-1:0] dly_d  [CHANNELS][TAPS];

  logic                     accept, ch_ok, coef_ok;
  logic                     mac_clr, mul_en, acc_en;
  logic [TAP_W-1:0]         tap_idx;
  logic signed [ACC_W-1:0]  acc;

  function automatic logic signed [OUT_W-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    logic signed [SAT_W-1:0] ext;
    ext = SAT_W'(a);
`ifdef FIR_SAT_EN
    ext = sat_round(ext, COEF_W - 1, OUT_W);
`endif
    return ext[OUT_W-1:0];
  endfunction

  // A pending clear blocks acceptance so the zeroing cannot race a shift.
  always_comb begin
    in_ready   = (state_q == IDLE) && started_q && !clear;
    accept     = in_valid && in_ready;
    ch_ok      = int'(in_ch) < CHANNELS;
    coef_ok    = coef_we && (state_q == IDLE) && !accept;
    coef_err_d = coef_we && !coef_ok;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    mac_clr = 1'b0;
    mul_en  = 1'b0;
    acc_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && ch_ok) begin
          state_d = MAC;
          cnt_d   = '0;
          ch_d    = in_ch;
          mac_clr = 1'b1;
        end
      end
      // cnt runs 0..TAPS: TAPS product issues, then one cycle to fold in the last product.
      MAC: begin
        mul_en = cnt_q < CNT_W'(TAPS);
        acc_en = cnt_q != '0;
        if (cnt_q == CNT_W'(TAPS)) state_d = OUT;
        else cnt_d = cnt_q + 1'b1;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dly_d  = dly_q;
    coef_d = coef_q;
    if (clear && (state_q == IDLE)) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) dly_d[c][k] = '0;
    end else if (accept && ch_ok) begin
      for (int k = TAPS - 1; k > 0; k--) dly_d[in_ch][k] = dly_q[in_ch][k-1];
      dly_d[in_ch][0] = x_in;
    end
    if (coef_ok) coef_d[coef_addr] = coef_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ch_q       <= '0;
      started_q  <= 1'b0;
      coef_err_q <= 1'b0;
      for (int k = 0; k < TAPS; k++) coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      for (int c = 0; c < CHANNELS; c++)
        for (int k = 0; k < TAPS; k++) dly_q[c][k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      started_q  <= 1'b1;
      coef_err_q <= coef_err_d;
      coef_q     <= coef_d;
      dly_q      <= dly_d;
    end
  end

  assign tap_idx = cnt_q[TAP_W-1:0];

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (mac_clr),
    .mul_en (mul_en),
    .acc_en (acc_en),
    .a      (dly_q[ch_q][tap_idx]),
    .b      (coef_q[tap_idx]),
    .acc    (acc)
  );

  assign out_valid = (state_q == OUT);
  assign out_ch    = ch_q;
  assign y_out     = fmt_out(acc);
  assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_filter_tdm.sv
// Scoreboard bench for fir_filter_tdm (default build): directed scenarios plus randomized traffic.
module tb_fir_filter_tdm;

  localparam int TAPS = 8;
  localparam int CHN  = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [1:0]         in_ch = '0;
  logic signed [15:0] x_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [1:0]         out_ch;
  logic signed [31:0] y_out;
  logic               coef_we = 1'b0;
  logic [2:0]         coef_addr = '0;
  logic signed [15:0] coef_data = '0;
  logic               coef_err;

  fir_filter_tdm dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .y_out     (y_out),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_err  (coef_err)
  );

  always #5 clk = ~clk;

  typedef struct {int ch; int y; int t;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit seen  = 0;
  bit rand_bp = 0;

  // Reference model: per-channel history (index 0 = newest) and coefficient table.
  int hist [CHN][TAPS];
  int cf   [TAPS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHN; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
    for (int k = 0; k < TAPS; k++) cf[k] = (k == 0) ? 1 : 0;
  endtask

  function automatic int model_y(input int ch);
    longint sum = 0;
    for (int k = 0; k < TAPS; k++) sum += longint'(hist[ch][k]) * longint'(cf[k]);
    return int'(sum);
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin chk("idle_timeout", 1, 0); break; end
    end
  endtask

  task automatic send(input int ch, input int x);
    int n = 0;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; in_ch = 2'(ch); x_in = 16'(x);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin chk("send_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = int'(signed'(16'(x)));
    e.ch = ch; e.y = model_y(ch); e.t = cyc;
    sb.push_back(e);
  endtask

  task automatic write_coef(input int addr, input int val);
    wait_idle();
    coef_we = 1'b1; coef_addr = 3'(addr); coef_data = 16'(val);
    @(posedge clk); #1;
    coef_we = 1'b0;
    cf[addr] = int'(signed'(16'(val)));
    @(negedge clk);
    chk("coef_err_idle", coef_err, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin @(negedge clk); n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() != 0) chk("latency", cyc - sb[0].t, TAPS + 1);
      end
      if (out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_ch", out_ch, e.ch);
          chk("y_out", y_out, e.y);
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_coef_err", coef_err, 0);
    reset_n = 1'b1;
    #1 chk("in_ready_first_cycle", in_ready, 0);
    @(negedge clk);
    chk("in_ready_after", in_ready, 1);

    // Pass-through impulse.
    send(0, 1);
    for (int i = 0; i < 3; i++) send(0, 0);
    drain();

    // Coefficient profile 1,2,3,4 then impulse response.
    for (int k = 0; k < TAPS; k++) write_coef(k, (k < 4) ? k + 1 : 0);
    send(0, 1);
    for (int i = 0; i < 7; i++) send(0, 0);
    drain();

    // Interleaved channels with gain 2.
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 2 : 0);
    send(1, 5);
    send(2, -3);
    send(3, 0);
    drain();

    // Backpressure hold.
    out_ready = 1'b0;
    send(1, 7);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(negedge clk); n++; end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      if (sb.size() != 0) begin
        chk("hold_y_out", y_out, sb[0].y);
        chk("hold_out_ch", out_ch, sb[0].ch);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2, 4);
    drain();

    // Coefficient write while busy is rejected.
    send(0, 6);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd99;
    @(posedge clk); #1;
    coef_we = 1'b0;
    @(negedge clk);
    chk("coef_err_pulse", coef_err, 1);
    @(negedge clk);
    chk("coef_err_single", coef_err, 0);
    drain();
    send(0, 3);
    write_coef(1, -5);
    send(0, 2);
    drain();

    // Clear competing with a valid sample.
    wait_idle();
    clear = 1'b1; in_valid = 1'b1; in_ch = 2'd0; x_in = 16'sd9;
    #1 chk("clear_blocks_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < CHN; c++)
      for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
    send(0, 9);
    send(1, 1);
    drain();

    // Asynchronous reset in the middle of a MAC run.
    send(2, 11);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_y_out", y_out, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_coef_err", coef_err, 0);
    sb.delete();
    seen = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    send(0, 1);
    send(0, 0);
    drain();

    // Randomized traffic with backpressure and idle coefficient writes.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0)
        write_coef($urandom_range(0, TAPS - 1), int'(signed'(16'($urandom))));
      else
        send($urandom_range(0, CHN - 1), int'(signed'(16'($urandom))));
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
